// File: rtl/req_arb_ctrl.sv
// req_arb_ctrl: request front end of the memory interface controller.
//
// Each of NREQS requesters pushes packets into its own show-ahead FIFO.
// When the controller is idle, a round-robin arbiter picks the first non-empty
// FIFO after the last granted one. The head packet is popped, and its address
// and write data are registered onto the memory port with a one-cycle
// read or write strobe. No further grant is made until mem_ack arrives.
// A completed read produces a one-cycle read_valid pulse for its requester.
//
// Packet layout (RWIDTH bits):
//   [0]                    write
//   [1]                    read
//   [AWIDTH+1:2]           address
//   [RWIDTH-1:AWIDTH+2]    write data
//
// Ports:
//   clock        in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   per-requester push strobe
//   req_data     in   per-requester packet
//   mem_ack      in   memory operation complete (ignored unless busy)
//   fifo_full    out  FIFO i holds RDEPTH entries
//   busy         out  a command is outstanding
//   grant_index  out  requester of the current/last command
//   mem_read     out  one-cycle read strobe
//   mem_write    out  one-cycle write strobe
//   mem_addr     out  registered address, held until the next grant
//   mem_wdata    out  registered write data, held until the next grant
//   read_valid   out  one-cycle pulse when requester i's read completes
//
// Optional build macro:
//   REQ_ARB_DEBUG_EN  simulation-only $display trace of strobes and read_valid.
//                     Behaviour is identical with or without it.

module req_arb_ctrl #(
  parameter int NREQS  = 4,
  parameter int PSIZE  = 64,
  parameter int AWIDTH = $clog2(NREQS * PSIZE),
  parameter int MWIDTH = 32,
  parameter int RWIDTH = AWIDTH + MWIDTH + 2,
  parameter int RDEPTH = 4,
  parameter int RBITS  = $clog2(NREQS)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQS-1:0]        req_valid,
  input  logic [RWIDTH-1:0]       req_data [0:NREQS-1],
  input  logic                    mem_ack,
  output logic [NREQS-1:0]        fifo_full,
  output logic                    busy,
  output logic [RBITS-1:0]        grant_index,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [AWIDTH-1:0]       mem_addr,
  output logic [MWIDTH-1:0]       mem_wdata,
  output logic [NREQS-1:0]        read_valid
);

  localparam int PBITS = $clog2(RDEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [RBITS-1:0]               last_grant;
  logic                           op_read;

  logic [NREQS-1:0]               not_empty;
  logic [NREQS-1:0]               push;
  logic [NREQS-1:0]               pop;
  logic [NREQS-1:0][RWIDTH-1:0]   head;

  logic                           win_found;
  logic [RBITS-1:0]               win_idx;
  logic [RWIDTH-1:0]              win_pkt;

  logic                           grant;
  logic                           write_d;
  logic                           read_d;
  logic [NREQS-1:0]               rv_d;

  // ---- Per-requester show-ahead FIFOs ----
  for (genvar i = 0; i < NREQS; i++) begin : g_fifo
    logic [RWIDTH-1:0] store [RDEPTH];
    logic [PBITS-1:0]  wr_ptr;
    logic [PBITS-1:0]  rd_ptr;
    logic [PBITS:0]    cnt;

    assign fifo_full[i] = (cnt == (PBITS + 1)'(RDEPTH));
    assign not_empty[i] = (cnt != '0);
    // A push into a full FIFO is dropped even if the same edge pops it.
    assign push[i]      = req_valid[i] & ~fifo_full[i];
    assign head[i]      = store[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PBITS'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PBITS'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt <= cnt + (PBITS + 1)'(1);
          2'b01:   cnt <= cnt - (PBITS + 1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage needs no reset: emptiness is tracked by cnt alone.
    always_ff @(posedge clock) begin
      if (push[i]) store[wr_ptr] <= req_data[i];
    end
  end

  // ---- Round-robin search starting just after the last grant ----
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQS; k++) begin
      int c;
      c = (int'(last_grant) + k) % NREQS;
      if (!win_found && not_empty[RBITS'(c)]) begin
        win_found = 1'b1;
        win_idx   = RBITS'(c);
      end
    end
  end

  assign win_pkt = head[win_idx];

  // ---- FSM: state register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      // A packet with neither op bit is consumed without leaving IDLE.
      S_IDLE: if (win_found && (win_pkt[0] || win_pkt[1])) state_d = S_WAIT;
      S_WAIT: if (mem_ack) state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs (next-cycle strobe values) ----
  always_comb begin
    grant   = (state_q == S_IDLE) && win_found;
    pop     = '0;
    if (grant) pop[win_idx] = 1'b1;
    // Write takes priority when both op bits are set.
    write_d = grant & win_pkt[0];
    read_d  = grant & ~win_pkt[0] & win_pkt[1];
    rv_d    = '0;
    if ((state_q == S_WAIT) && mem_ack && op_read) rv_d[grant_index] = 1'b1;
  end

  assign busy = (state_q == S_WAIT);

  // ---- Registered memory-port outputs ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      read_valid  <= '0;
      grant_index <= '0;
      last_grant  <= RBITS'(NREQS - 1);
      op_read     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_write  <= write_d;
      mem_read   <= read_d;
      read_valid <= rv_d;
      if (grant) begin
        grant_index <= win_idx;
        last_grant  <= win_idx;
        op_read     <= read_d;
        mem_addr    <= win_pkt[AWIDTH+1:2];
        mem_wdata   <= win_pkt[RWIDTH-1:AWIDTH+2];
      end
    end
  end

`ifdef REQ_ARB_DEBUG_EN
  always @(posedge clock) begin
    if (reset_n) begin
      if (mem_write)
        $display("[MIC %0t] Memory Write: Addr=0x%h Data=0x%h", $time, mem_addr, mem_wdata);
      if (mem_read)
        $display("[MIC %0t] Memory Read: Addr=0x%h", $time, mem_addr);
      for (int i = 0; i < NREQS; i++)
        if (read_valid[i]) $display("[MIC %0t] Read Valid: Req=%0d", $time, i);
    end
  end
`else
`endif

endmodule

// File: tb/tb_req_arb_ctrl.sv
module tb_req_arb_ctrl;
  localparam int NREQS  = 4;
  localparam int AW     = 8;
  localparam int MW     = 32;
  localparam int RW     = AW + MW + 2;
  localparam int RDEPTH = 4;
  localparam int RB     = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQS-1:0]  req_valid;
  logic [RW-1:0]     req_data [0:NREQS-1];
  logic              mem_ack;
  logic [NREQS-1:0]  fifo_full;
  logic              busy;
  logic [RB-1:0]     grant_index;
  logic              mem_read;
  logic              mem_write;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wdata;
  logic [NREQS-1:0]  read_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  req_arb_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .mem_ack     (mem_ack),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .grant_index (grant_index),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .read_valid  (read_valid)
  );

  // Behavioural reference: one queue per requester plus transaction state.
  logic [RW-1:0]    mq [NREQS][$];
  bit               m_busy;
  bit               m_opr;
  int               m_last;
  int               m_gidx;
  logic             e_wr, e_rd;
  logic [AW-1:0]    e_addr;
  logic [MW-1:0]    e_wd;
  logic [NREQS-1:0] e_rv;

  function automatic logic [RW-1:0] mk(logic wr, logic rd, logic [AW-1:0] a, logic [MW-1:0] d);
    return {d, a, rd, wr};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    mem_ack   = 1'b0;
    for (int i = 0; i < NREQS; i++) req_data[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    got = 0;
    repeat (budget) begin
      if (mem_write || mem_read) begin
        got = 1;
        break;
      end
      cyc();
    end
    if (!got) got = mem_write || mem_read;
  endtask

  task automatic model_init();
    for (int i = 0; i < NREQS; i++) mq[i].delete();
    m_busy = 0; m_opr = 0; m_last = NREQS - 1; m_gidx = 0;
    e_wr = 0; e_rd = 0; e_addr = '0; e_wd = '0; e_rv = '0;
  endtask

  // Applies the arbitration rules to the queues for one clock edge.
  task automatic model_step();
    bit            was_full [NREQS];
    logic [RW-1:0] pkt;
    int            w;
    for (int i = 0; i < NREQS; i++) was_full[i] = (mq[i].size() == RDEPTH);
    e_rv = '0;
    if (m_busy && mem_ack && m_opr) e_rv[m_gidx] = 1'b1;
    e_wr = 0;
    e_rd = 0;
    if (!m_busy) begin
      w = -1;
      for (int k = 1; k <= NREQS; k++) begin
        int c;
        c = (m_last + k) % NREQS;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w >= 0) begin
        pkt    = mq[w].pop_front();
        m_gidx = w;
        m_last = w;
        e_addr = pkt[AW+1:2];
        e_wd   = pkt[RW-1:AW+2];
        if (pkt[0]) begin
          e_wr = 1; m_busy = 1; m_opr = 0;
        end else if (pkt[1]) begin
          e_rd = 1; m_busy = 1; m_opr = 1;
        end
      end
    end else if (mem_ack) begin
      m_busy = 0;
    end
    for (int i = 0; i < NREQS; i++)
      if (req_valid[i] && !was_full[i]) mq[i].push_back(req_data[i]);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got %0b want 0", mem_write); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %0b want 0", mem_read); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (grant_index !== 2'd0) begin n_bad++; $display("FAIL reset_grant_index got %0d want 0", grant_index); end
    n_cmp++; if (read_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_read_valid got %b want 0000", read_valid); end
    n_cmp++; if (fifo_full !== 4'b0000) begin n_bad++; $display("FAIL reset_fifo_full got %b want 0000", fifo_full); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_write();
    req_valid = 4'b0001;
    req_data[0] = mk(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    cyc();
    req_valid = '0;
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL wr_same_edge got %0b want 0", mem_write); end
    cyc();
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL wr_strobe got %0b want 1", mem_write); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_bad++; $display("FAIL wr_addr got %h want 10", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data got %h want deadbeef", mem_wdata); end
    n_cmp++; if (grant_index !== 2'd0) begin n_bad++; $display("FAIL wr_gidx got %0d want 0", grant_index); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy got %0b want 1", busy); end
    cyc();
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL wr_one_cycle got %0b want 0", mem_write); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_hold got %0b want 1", busy); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_ack_busy got %0b want 0", busy); end
    n_cmp++; if (read_valid !== 4'b0000) begin n_bad++; $display("FAIL wr_no_rv got %b want 0000", read_valid); end
    cyc();
    n_cmp++; if (read_valid !== 4'b0000) begin n_bad++; $display("FAIL wr_no_rv2 got %b want 0000", read_valid); end
  endtask

  task automatic test_read();
    req_valid = 4'b0100;
    req_data[2] = mk(1'b0, 1'b1, 8'h10, 32'h0);
    cyc();
    req_valid = '0;
    cyc();
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rd_strobe got %0b want 1", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rd_no_write got %0b want 0", mem_write); end
    n_cmp++; if (grant_index !== 2'd2) begin n_bad++; $display("FAIL rd_gidx got %0d want 2", grant_index); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_bad++; $display("FAIL rd_addr got %h want 10", mem_addr); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    n_cmp++; if (read_valid !== 4'b0100) begin n_bad++; $display("FAIL rd_valid got %b want 0100", read_valid); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rd_one_cycle got %0b want 0", mem_read); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy got %0b want 0", busy); end
    cyc();
    n_cmp++; if (read_valid !== 4'b0000) begin n_bad++; $display("FAIL rd_valid_pulse got %b want 0000", read_valid); end
  endtask

  task automatic test_round_robin();
    bit got;
    int order [6] = '{0, 1, 2, 3, 1, 3};
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQS; i++) req_data[i] = mk(1'b1, 1'b0, 8'h40 + 8'(i), 32'h1000 + i);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        req_valid = 4'b1010;
        req_data[1] = mk(1'b1, 1'b0, 8'h41, 32'h2001);
        req_data[3] = mk(1'b1, 1'b0, 8'h43, 32'h2003);
        cyc();
        req_valid = '0;
      end
      wait_strobe(10, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL rr_timeout slot %0d got no strobe want strobe", k);
      end else if (grant_index !== 2'(order[k]) || mem_addr !== 8'h40 + 8'(order[k])) begin
        n_bad++; $display("FAIL rr_order slot %0d got gidx=%0d addr=%h want gidx=%0d", k, grant_index, mem_addr, order[k]);
      end
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_full();
    bit got;
    int cnt;
    do_reset();
    req_valid = 4'b0001;
    req_data[0] = mk(1'b1, 1'b0, 8'h01, 32'h1);
    cyc();
    req_valid = '0;
    wait_strobe(10, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL full_first got no strobe want strobe"); end
    for (int p = 1; p <= 5; p++) begin
      req_valid = 4'b0010;
      req_data[1] = mk(1'b1, 1'b0, 8'h80 + 8'(p), 32'(p));
      cyc();
      n_cmp++;
      if (fifo_full[1] !== (p >= 4)) begin
        n_bad++; $display("FAIL full_flag push %0d got %0b want %0b", p, fifo_full[1], (p >= 4));
      end
    end
    req_valid = '0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (mem_write) begin
        n_cmp++;
        if (grant_index !== 2'd1 || mem_addr !== 8'h80 + 8'(cnt + 1)) begin
          n_bad++; $display("FAIL full_issue %0d got gidx=%0d addr=%h want gidx=1 addr=%h", cnt, grant_index, mem_addr, 8'h80 + 8'(cnt + 1));
        end
        cnt++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
      cyc();
    end
    mem_ack = 1'b0;
    n_cmp++; if (cnt !== 4) begin n_bad++; $display("FAIL full_count got %0d want 4", cnt); end
    n_cmp++; if (fifo_full !== 4'b0000) begin n_bad++; $display("FAIL full_drain got %b want 0000", fifo_full); end
  endtask

  task automatic test_bits();
    do_reset();
    req_valid = 4'b0001;
    req_data[0] = mk(1'b1, 1'b1, 8'h21, 32'h5);
    cyc();
    req_valid = '0;
    cyc();
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL both_write got %0b want 1", mem_write); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL both_read got %0b want 0", mem_read); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    req_valid = 4'b0010;
    req_data[1] = mk(1'b0, 1'b0, 8'h33, 32'h7);
    cyc();
    req_valid = '0;
    cyc();
    n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_bad++; $display("FAIL none_strobe got w=%0b r=%0b want 0 0", mem_write, mem_read); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL none_busy got %0b want 0", busy); end
    n_cmp++; if (grant_index !== 2'd1) begin n_bad++; $display("FAIL none_gidx got %0d want 1", grant_index); end
    n_cmp++; if (mem_addr !== 8'h33) begin n_bad++; $display("FAIL none_addr got %h want 33", mem_addr); end
    cyc();
    n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL none_after got w=%0b r=%0b b=%0b want 0 0 0", mem_write, mem_read, busy); end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    req_valid = 4'b0001;
    req_data[0] = mk(1'b1, 1'b0, 8'h0A, 32'hA);
    cyc();
    req_valid = '0;
    wait_strobe(10, got);
    for (int p = 0; p < 3; p++) begin
      req_valid = 4'b0010;
      req_data[1] = mk(1'b1, 1'b0, 8'h60 + 8'(p), 32'hB0 + p);
      cyc();
    end
    req_valid = '0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre_busy got %0b want 1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %0b want 0", busy); end
    n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_data got addr=%h data=%h want 0 0", mem_addr, mem_wdata); end
    n_cmp++; if (grant_index !== 2'd0 || read_valid !== 4'b0000 || fifo_full !== 4'b0000) begin n_bad++; $display("FAIL mid_ctrl got gidx=%0d rv=%b full=%b want 0", grant_index, read_valid, fifo_full); end
    cyc();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_cmp++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL mid_after cycle %0d got w=%0b r=%0b b=%0b want 0 0 0", c, mem_write, mem_read, busy);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    model_init();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQS; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 30);
        r = $urandom_range(0, 9);
        req_data[i] = mk(r >= 1 && r <= 4 || r == 9, r >= 5, 8'($urandom), $urandom);
      end
      mem_ack = ($urandom_range(0, 99) < 40);
      @(posedge clock);
      model_step();
      #1;
      n_cmp++; if (mem_write !== e_wr) begin n_bad++; $display("FAIL rnd_write cycle %0d got %0b want %0b", c, mem_write, e_wr); end
      n_cmp++; if (mem_read !== e_rd) begin n_bad++; $display("FAIL rnd_read cycle %0d got %0b want %0b", c, mem_read, e_rd); end
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy cycle %0d got %0b want %0b", c, busy, m_busy); end
      n_cmp++; if (grant_index !== 2'(m_gidx)) begin n_bad++; $display("FAIL rnd_gidx cycle %0d got %0d want %0d", c, grant_index, m_gidx); end
      n_cmp++; if (read_valid !== e_rv) begin n_bad++; $display("FAIL rnd_rv cycle %0d got %b want %b", c, read_valid, e_rv); end
      n_cmp++; if (mem_addr !== e_addr || mem_wdata !== e_wd) begin n_bad++; $display("FAIL rnd_port cycle %0d got %h/%h want %h/%h", c, mem_addr, mem_wdata, e_addr, e_wd); end
      for (int i = 0; i < NREQS; i++) begin
        n_cmp++;
        if (fifo_full[i] !== (mq[i].size() == RDEPTH)) begin
          n_bad++; $display("FAIL rnd_full cycle %0d req %0d got %0b want %0b", c, i, fifo_full[i], (mq[i].size() == RDEPTH));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_full();
    test_bits();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
